// File: rtl/cnn_mem_reader_if.sv
// Memory-side Avalon-MM read port plus the outgoing byte stream of cnn_mem_reader.
// The reader drives the master modport; memory model and stream consumer sit on the slave side.
interface cnn_mem_reader_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              waitrequest;
  logic [7:0]        readdata;
  logic              readdatavalid;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output address, read, out_data, out_valid, out_last,
    input  waitrequest, readdata, readdatavalid, out_ready
  );

  modport slave (
    input  address, read, out_data, out_valid, out_last,
    output waitrequest, readdata, readdatavalid, out_ready
  );
endinterface

// File: rtl/cnn_mem_reader.sv
// Avalon-MM read master streaming a contiguous byte block to the CNN datapath.
// Outstanding reads are credit-limited by the local FIFO so returning bytes are never dropped.
module cnn_mem_reader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  cnn_mem_reader_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d;
  logic [LEN_W-1:0]  req_left_q, req_left_d;
  logic [LEN_W-1:0]  rsp_left_q, rsp_left_d;
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic              zero_done_q, zero_done_d;

  logic accept_c;
  logic push_c;
  logic pop_c;
  logic last_pop_c;

  assign accept_c   = read_q & ~bus.waitrequest;
  assign push_c     = bus.readdatavalid & (state_q != IDLE);
  assign pop_c      = (fifo_count_q != '0) & bus.out_ready;
  assign last_pop_c = pop_c & (rsp_left_q == LEN_W'(1)) & (state_q == DRAIN);

  assign bus.address   = address_q;
  assign bus.read      = read_q;
  assign bus.out_valid = (fifo_count_q != '0);
  assign bus.out_data  = (fifo_count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.out_last  = (fifo_count_q != '0) & (rsp_left_q == LEN_W'(1));
  assign busy          = (state_q != IDLE);
  assign done          = zero_done_q | last_pop_c;

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = 1'b0;
    req_left_d   = req_left_q;
    rsp_left_d   = rsp_left_q;
    in_flight_d  = in_flight_q;
    fifo_count_d = fifo_count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    zero_done_d  = 1'b0;

    // FIFO and credit bookkeeping shared by FETCH and DRAIN
    if (push_c) begin
      mem_d[wr_ptr_q] = bus.readdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rsp_left_d = rsp_left_q - LEN_W'(1);
    end
    fifo_count_d = fifo_count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    in_flight_d  = in_flight_q + CNT_W'(accept_c) - CNT_W'(push_c);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d    = FETCH;
            address_d  = base_addr;
            req_left_d = length;
            rsp_left_d = length;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (accept_c) begin
          address_d  = address_q + ADDR_W'(1);
          req_left_d = req_left_q - LEN_W'(1);
          if (req_left_d == '0) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_pop_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered request: issue only while credit covers both in-flight and buffered bytes
    read_d = (state_d == FETCH) && (req_left_d != '0) &&
             ((SUM_W'(in_flight_d) + SUM_W'(fifo_count_d)) < SUM_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      address_q    <= '0;
      read_q       <= 1'b0;
      req_left_q   <= '0;
      rsp_left_q   <= '0;
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_q        <= '{default: 8'h00};
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      req_left_q   <= req_left_d;
      rsp_left_q   <= rsp_left_d;
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
      zero_done_q  <= zero_done_d;
    end
  end

endmodule

// File: tb/tb_cnn_mem_reader.sv
// Directed and randomized checks of cnn_mem_reader against a byte-array memory model.
// Expected streams and addresses come straight from base/length arithmetic over that array.
module tb_cnn_mem_reader;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy;
  logic              done;

  cnn_mem_reader_if #(.ADDR_W(ADDR_W)) bus ();

  cnn_mem_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];

  int n_checks = 0;
  int n_err    = 0;

  // memory slave state
  typedef struct { logic [7:0] d; int due; } rsp_t;
  rsp_t        pend[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rand_wait = 0;
  int          stall_cnt = 0;
  int          stall_cyc[$];
  logic [15:0] stall_addr[$];
  int          acc_cyc[$];
  logic [15:0] acc_addr[$];

  // stream monitor state
  logic [7:0] got_d[$];
  bit         got_l[$];
  int         done_cnt = 0;
  int         done_ok = 0;

  initial begin
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.readdata      = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      bus.readdatavalid = 1'b0;
      bus.readdata      = 8'h00;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = pend[0].d;
        void'(pend.pop_front());
      end
      bus.waitrequest = 1'b0;
      if (bus.read === 1'b1) begin
        if (stall_cnt > 0) begin
          bus.waitrequest = 1'b1;
          stall_cnt--;
          stall_cyc.push_back(cyc);
          stall_addr.push_back(bus.address);
        end else if (rand_wait && $urandom_range(0, 3) == 0) begin
          bus.waitrequest = 1'b1;
        end else begin
          acc_addr.push_back(bus.address);
          acc_cyc.push_back(cyc);
          pend.push_back('{mem[bus.address], cyc + lat});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.out_last === 1'b1) done_ok++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_d.delete();
    got_l.delete();
    acc_addr.delete();
    acc_cyc.delete();
    stall_cyc.delete();
    stall_addr.delete();
    done_cnt = 0;
    done_ok  = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_read"}, bus.read, 0);
    check({tag, "_addr"}, bus.address, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_last"}, bus.out_last, 0);
    check({tag, "_data"}, bus.out_data, 0);
  endtask

  task automatic begin_xfer(input logic [15:0] b, input logic [15:0] l);
    clear_logs();
    start = 1'b1;
    base_addr = b;
    length = l;
    tick();
    start = 1'b0;
    base_addr = 16'($urandom);
    length = 16'($urandom);
    if (l != 16'd0) begin
      check("busy_rise", busy, 1);
      check("first_read", bus.read, 1);
      check("first_addr", bus.address, 32'(b));
    end
  endtask

  task automatic finish_xfer(input logic [15:0] b, input int l, input bit rand_ready);
    int k;
    logic [15:0] a;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      if (rand_ready) bus.out_ready = 1'($urandom);
      tick();
      k++;
    end
    check("busy_fall", busy, 0);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("done_count", done_cnt, 1);
    check("done_on_last", done_ok, 1);
    check("n_bytes", got_d.size(), l);
    check("n_reads", acc_addr.size(), l);
    for (int i = 0; i < l; i++) begin
      a = b + 16'(i);
      if (i < got_d.size()) begin
        check($sformatf("data[%0d]", i), got_d[i], 32'(mem[a]));
        check($sformatf("last[%0d]", i), got_l[i], (i == l - 1) ? 1 : 0);
      end
      if (i < acc_addr.size()) check($sformatf("addr[%0d]", i), acc_addr[i], 32'(a));
    end
  endtask

  initial begin
    int k;
    int n;
    logic [15:0] rb;
    int rl;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hA1;
    mem[16'h0011] = 8'hA2;
    mem[16'h0012] = 8'hA3;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) tick();
    check_idle_outputs("rst");
    reset = 1'b0;
    tick();
    check_idle_outputs("post_rst");

    // basic read
    lat = 1;
    begin_xfer(16'h0010, 16'd3);
    finish_xfer(16'h0010, 3, 0);

    // waitrequest on the first request
    stall_cnt = 3;
    begin_xfer(16'h0010, 16'd3);
    finish_xfer(16'h0010, 3, 0);
    check("stall_n", stall_cyc.size(), 3);
    for (int i = 0; i < stall_cyc.size(); i++) begin
      check($sformatf("stall_cyc[%0d]", i), stall_cyc[i], stall_cyc[0] + i);
      check($sformatf("stall_addr[%0d]", i), stall_addr[i], 32'h10);
    end
    if (stall_cyc.size() > 0 && acc_cyc.size() > 0)
      check("accept_after_stall", acc_cyc[0], stall_cyc[stall_cyc.size() - 1] + 1);

    // backpressure: credit limit stops requests at DEPTH
    bus.out_ready = 1'b0;
    begin_xfer(16'h0100, 16'd8);
    repeat (10) tick();
    check("bp_reads", acc_addr.size(), DEPTH);
    check("bp_read_low", bus.read, 0);
    check("bp_valid", bus.out_valid, 1);
    check("bp_no_pop", got_d.size(), 0);
    bus.out_ready = 1'b1;
    finish_xfer(16'h0100, 8, 0);

    // zero length
    clear_logs();
    start = 1'b1;
    length = 16'd0;
    base_addr = 16'h0055;
    tick();
    start = 1'b0;
    check("zl_done", done, 1);
    check("zl_busy", busy, 0);
    tick();
    check("zl_done_fall", done, 0);
    check("zl_reads", acc_addr.size(), 0);
    check("zl_done_cnt", done_cnt, 1);
    check("zl_read", bus.read, 0);

    // start while busy is ignored
    begin_xfer(16'h0200, 16'd5);
    tick();
    start = 1'b1;
    base_addr = 16'h0300;
    length = 16'd2;
    tick();
    start = 1'b0;
    finish_xfer(16'h0200, 5, 0);

    // address wrap
    begin_xfer(16'hFFFE, 16'd4);
    finish_xfer(16'hFFFE, 4, 0);

    // reset mid-transfer
    lat = 3;
    begin_xfer(16'h0400, 16'd6);
    k = 0;
    while (got_d.size() < 2 && k < 200) begin
      tick();
      k++;
    end
    check("mid_reached", (got_d.size() >= 2) ? 1 : 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("mid_rst");
    n = got_d.size();
    repeat (8) begin
      tick();
      check("mid_idle_valid", bus.out_valid, 0);
    end
    check("mid_no_more_bytes", got_d.size(), n);
    check("mid_no_done", done_cnt, 0);
    check("mid_busy", busy, 0);
    lat = 1;
    begin_xfer(16'h0400, 16'd6);
    finish_xfer(16'h0400, 6, 0);

    // randomized transfers with random stalls, latency and backpressure
    rand_wait = 1;
    for (int r = 0; r < 8; r++) begin
      lat = $urandom_range(1, 3);
      rb = 16'($urandom);
      rl = $urandom_range(1, 20);
      begin_xfer(rb, 16'(rl));
      finish_xfer(rb, rl, 1);
    end
    rand_wait = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_mem_reader.md
# cnn_mem_reader

Avalon-MM read master that fetches a contiguous block of bytes from the CNN byte memory peripheral and delivers them in order as a valid/ready byte stream to the CNN datapath. It sits between the memory-mapped parameter/image store, which the HPS fills, and the compute core that consumes weights and pixels. Outstanding reads are credit-limited by an internal FIFO, so stream backpressure never drops a returning byte.

## Interface
- ADDR_W, 16, byte address width of the memory-side master port
- LEN_W, 16, width of the transfer length
- DEPTH, 4, FIFO depth in bytes and the maximum number of in-flight reads; a power of 2, at least 2

- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- base_addr  in  ADDR_W  first byte address; captured on an accepted start
- length  in  LEN_W  number of bytes to transfer; captured on an accepted start
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse when the last byte is consumed on the stream
- address  out  ADDR_W  master read address
- read  out  1  master read request
- waitrequest  in  1  slave stall; a request is accepted when read=1 and waitrequest=0
- readdata  in  8  returned byte
- readdatavalid  in  1  readdata is valid this cycle; responses return in request order
- out_data  out  8  stream byte (FIFO head)
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts when out_valid=1 and out_ready=1
- out_last  out  1  qualifies the final byte of the transfer

## Operation
- The state machine has three states: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 with length>0 captures base_addr, loads req_left=length and rsp_left=length, and moves to FETCH.
  - start=1 with length=0 moves nowhere, issues no read, and pulses done in the next cycle. busy stays 0.
- FETCH:
  - read=1 when req_left>0 and (in_flight + fifo_count) < DEPTH.
  - address = base_addr + number of requests already accepted, truncated to ADDR_W, so it wraps modulo 2^ADDR_W.
  - Each accepted request decrements req_left and increments in_flight.
  - When req_left reaches 0, go to DRAIN.
- readdatavalid (FETCH or DRAIN): push readdata into the FIFO and decrement in_flight. The credit rule guarantees the FIFO is never full at that point.
- Stream side:
  - out_valid = (fifo_count>0); out_data = FIFO head.
  - A handshake pops the head and decrements rsp_left.
  - out_last = out_valid and rsp_left==1.
- DRAIN: the last stream handshake (rsp_left 1→0) moves to IDLE and asserts done in that same cycle.
- start outside IDLE is ignored. A readdatavalid that arrives in IDLE is dropped.
- A simultaneous push and pop leaves fifo_count unchanged. A simultaneous accept and response leaves in_flight unchanged.

## Timing
- Reset values: state IDLE, busy 0, done 0, read 0, address 0, out_valid 0, out_last 0, out_data 0. FIFO, in_flight, req_left and rsp_left are all cleared.
- A reset asserted mid-transfer aborts it in the same cycle. No done pulse is produced.
- An accepted start (cycle T) raises busy and enters FETCH at T+1. The first read is asserted at T+1.
- read and address are registered. While waitrequest=1 they hold stable, with read kept high.
- After an acceptance, the next request may be issued in the following cycle. Peak throughput is 1 byte/cycle.
- A byte returned by readdatavalid in cycle R appears on out_valid at R+1.
- done is asserted in the same cycle as the handshake on the out_last byte, and busy falls in the next cycle.
- A new start is accepted in the cycle after done.

## Test plan
- Basic read: base 0x0010, length 3, memory holds 0xA1, 0xA2, 0xA3 at a fixed 1-cycle latency, out_ready=1 -> reads issued to 0x10, 0x11, 0x12; stream carries A1, A2, A3; out_last only on A3; done pulses once.
- Waitrequest: hold waitrequest=1 for 3 cycles on the first request -> read and address stay at 1 and 0x0010 throughout, with no duplicate accept. Output order is unchanged.
- Backpressure: length 8, DEPTH=4, out_ready=0 for 10 cycles -> exactly 4 reads are accepted, then read=0. Releasing out_ready streams all 8 bytes in order with no loss.
- Zero length and ignored start: start with length 0 -> done pulses in the next cycle with no reads. start pulsed during a busy transfer -> no effect.
- Wrap: ADDR_W=16, base 0xFFFE, length 4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-transfer: assert reset after 2 of 6 bytes -> all outputs return to reset values next cycle and no done pulse. A late readdatavalid is dropped. A new start then works normally.
